// File: rtl/bin_from_bcd.sv
// Sequential BCD-to-binary converter: one multiply-by-10-and-add step per clock, MSD first.
// Optional HACK_RANGE_EN limits the result to 32767 (largest Hack A-instruction constant).
module bin_from_bcd #(
  parameter int unsigned NDIG = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [4*NDIG-1:0] digits,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [15:0]       num,
  output logic              err,
  output logic              ovf
);

  localparam int unsigned IdxW = (NDIG > 1) ? $clog2(NDIG) : 1;

  typedef enum logic [1:0] {StIdle, StConv, StDone} state_e;

  state_e            state_q, state_d;
  logic [16:0]       acc_q, acc_d;
  logic              err_q, err_d;
  logic              ovf_q, ovf_d;
  logic [IdxW-1:0]   idx_q, idx_d;
  logic [4*NDIG-1:0] dig_q, dig_d;

  logic [3:0]  nib;
  logic [19:0] prod;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= StIdle;
      acc_q   <= '0;
      err_q   <= 1'b0;
      ovf_q   <= 1'b0;
      idx_q   <= '0;
      dig_q   <= '0;
    end else begin
      state_q <= state_d;
      acc_q   <= acc_d;
      err_q   <= err_d;
      ovf_q   <= ovf_d;
      idx_q   <= idx_d;
      dig_q   <= dig_d;
    end
  end

  // Digits are shifted out of a private copy so the input bus may change after acceptance.
  assign nib  = dig_q[4*NDIG-1 -: 4];
  assign prod = 20'(acc_q) * 20'd10 + 20'(nib);

  always_comb begin
    state_d   = state_q;
    acc_d     = acc_q;
    err_d     = err_q;
    ovf_d     = ovf_q;
    idx_d     = idx_q;
    dig_d     = dig_q;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    unique case (state_q)
      StIdle: begin
        in_ready = 1'b1;
        if (in_valid) begin
          dig_d   = digits;
          acc_d   = '0;
          err_d   = 1'b0;
          ovf_d   = 1'b0;
          idx_d   = IdxW'(NDIG - 1);
          state_d = StConv;
        end
      end
      StConv: begin
        if (nib > 4'd9) err_d = 1'b1;
        if (prod > 20'd65535) begin
          ovf_d = 1'b1;
          acc_d = 17'd65535;
        end else begin
          acc_d = prod[16:0];
        end
        dig_d = dig_q << 4;
        idx_d = idx_q - 1'b1;
        if (idx_q == '0) begin
          state_d = StDone;
`ifdef HACK_RANGE_EN
          if (acc_d > 17'd32767) ovf_d = 1'b1;
`endif
        end
      end
      StDone: begin
        out_valid = 1'b1;
        if (out_ready) state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_comb begin
    num = acc_q[15:0];
`ifdef HACK_RANGE_EN
    if (acc_q > 17'd32767) num = 16'd32767;
`endif
    if (err_q) num = '0;
  end

  assign err = err_q;
  assign ovf = ovf_q;

endmodule

// File: tb/tb_bin_from_bcd.sv
// Randomized self-checking bench for bin_from_bcd; NDIG=4 and NDIG=5 instances share clk/rst.
module tb_bin_from_bcd;

  logic        clk = 1'b0;
  logic        rst;
  logic        iv;
  logic [19:0] dig;
  logic        ordy;
  logic        sel;

  logic        ir4, ov4, err4, ovf4;
  logic [15:0] num4;
  logic        ir5, ov5, err5, ovf5;
  logic [15:0] num5;

  logic        cur_ir, cur_ov, cur_err, cur_ovf;
  logic [15:0] cur_num;

  int n_vec = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  bin_from_bcd #(.NDIG(4)) u_dut4 (
    .clk      (clk),
    .rst      (rst),
    .in_valid (iv & ~sel),
    .in_ready (ir4),
    .digits   (dig[15:0]),
    .out_valid(ov4),
    .out_ready(ordy & ~sel),
    .num      (num4),
    .err      (err4),
    .ovf      (ovf4)
  );

  bin_from_bcd #(.NDIG(5)) u_dut5 (
    .clk      (clk),
    .rst      (rst),
    .in_valid (iv & sel),
    .in_ready (ir5),
    .digits   (dig),
    .out_valid(ov5),
    .out_ready(ordy & sel),
    .num      (num5),
    .err      (err5),
    .ovf      (ovf5)
  );

  assign cur_ir  = sel ? ir5  : ir4;
  assign cur_ov  = sel ? ov5  : ov4;
  assign cur_num = sel ? num5 : num4;
  assign cur_err = sel ? err5 : err4;
  assign cur_ovf = sel ? ovf5 : ovf4;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // Whole decimal value from raw nibbles; saturation is monotonic so the final value decides ovf.
  task automatic model(input logic [19:0] d, input int n,
                       output logic [15:0] e_num, output logic e_err, output logic e_ovf);
    longint v;
    int     nb;
    v     = 0;
    e_err = 1'b0;
    for (int i = n - 1; i >= 0; i--) begin
      nb = int'((d >> (4 * i)) & 20'hF);
      v  = v * 10 + nb;
      if (nb > 9) e_err = 1'b1;
    end
`ifdef HACK_RANGE_EN
    e_ovf = (v > 32767);
    e_num = e_err ? 16'd0 : (e_ovf ? 16'd32767 : 16'(v));
`else
    e_ovf = (v > 65535);
    e_num = e_err ? 16'd0 : (e_ovf ? 16'd65535 : 16'(v));
`endif
  endtask

  task automatic run_txn(input logic s, input logic [19:0] d, input int stall, input bit inject);
    logic [15:0] e_num;
    logic        e_err, e_ovf;
    int          n;
    int          cyc;
    n = s ? 5 : 4;
    model(d, n, e_num, e_err, e_ovf);
    @(negedge clk);
    sel = s;
    iv  = 1'b1;
    dig = d;
    check("in_ready_idle", 32'(cur_ir), 32'd1);
    @(negedge clk);
    iv  = 1'b0;
    dig = 20'($urandom);
    cyc = 0;
    while (!cur_ov && cyc < 30) begin
      check("in_ready_conv", 32'(cur_ir), 32'd0);
      if (inject && cyc == 1) begin
        iv  = 1'b1;
        dig = 20'h00099;
      end else begin
        iv = 1'b0;
      end
      @(negedge clk);
      cyc++;
    end
    iv = 1'b0;
    check("latency", 32'(cyc), 32'(n));
    for (int k = 0; k < stall; k++) begin
      check("stall_valid", 32'(cur_ov), 32'd1);
      check("stall_num", 32'(cur_num), 32'(e_num));
      check("in_ready_done", 32'(cur_ir), 32'd0);
      @(negedge clk);
    end
    check("num", 32'(cur_num), 32'(e_num));
    check("err", 32'(cur_err), 32'(e_err));
    check("ovf", 32'(cur_ovf), 32'(e_ovf));
    ordy = 1'b1;
    @(negedge clk);
    ordy = 1'b0;
    check("valid_drop", 32'(cur_ov), 32'd0);
    check("in_ready_back", 32'(cur_ir), 32'd1);
  endtask

  task automatic check_reset_vals(input string tag);
    check({tag, "_in_ready"}, 32'(cur_ir), 32'd1);
    check({tag, "_out_valid"}, 32'(cur_ov), 32'd0);
    check({tag, "_num"}, 32'(cur_num), 32'd0);
    check({tag, "_err"}, 32'(cur_err), 32'd0);
    check({tag, "_ovf"}, 32'(cur_ovf), 32'd0);
  endtask

  initial begin
    logic [19:0] d;
    rst  = 1'b1;
    iv   = 1'b0;
    ordy = 1'b0;
    dig  = '0;
    sel  = 1'b0;
    #23;
    check_reset_vals("rst4");
    sel = 1'b1;
    #1;
    check_reset_vals("rst5");
    sel = 1'b0;
    @(negedge clk);
    rst = 1'b0;

    run_txn(1'b0, 20'h01234, 0, 1'b0);
    run_txn(1'b0, 20'h09999, 5, 1'b0);
    run_txn(1'b0, 20'h012A4, 0, 1'b0);
    run_txn(1'b0, 20'h00042, 0, 1'b0);
    run_txn(1'b1, 20'h65536, 1, 1'b0);
    run_txn(1'b1, 20'h40000, 0, 1'b0);
    run_txn(1'b1, 20'h99999, 0, 1'b0);
    run_txn(1'b1, 20'hFFFFF, 0, 1'b0);
    run_txn(1'b0, 20'h00321, 2, 1'b1);

    // Reset during the second conversion cycle aborts the transaction.
    @(negedge clk);
    sel = 1'b0;
    iv  = 1'b1;
    dig = 20'h05678;
    @(negedge clk);
    iv = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    #1;
    check_reset_vals("midrst");
    @(negedge clk);
    rst = 1'b0;
    run_txn(1'b0, 20'h00007, 0, 1'b0);

    for (int t = 0; t < 40; t++) begin
      d = '0;
      for (int i = 0; i < 5; i++) begin
        if ($urandom_range(0, 9) == 0) d[4*i +: 4] = 4'($urandom_range(0, 15));
        else d[4*i +: 4] = 4'($urandom_range(0, 9));
      end
      run_txn(1'($urandom_range(0, 1)), d, int'($urandom_range(0, 3)), 1'($urandom_range(0, 1)));
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/bin_from_bcd.md
Name: bin_from_bcd

Overview:
- Sequential BCD-to-binary converter; inverse of the display-side binary-to-BCD digit splitter.
- Takes NDIG packed decimal digits and produces a 16-bit unsigned integer for the Hack datapath.
- Typical sources: keypad or UART decimal entry.
- Uses one multiply-by-10-and-add step per clock, most significant digit first, with valid/ready handshakes on both sides.

Parameters:
NDIG, 4, number of BCD digits per transaction (legal range 1..5).

Ports:
clk  input  1  system clock, rising edge
rst  input  1  asynchronous reset, active-high
in_valid  input  1  digit bundle valid
in_ready  output  1  converter can accept a bundle
digits  input  4*NDIG  packed BCD; [3:0] = ones, [7:4] = tens, ..., top nibble = most significant
out_valid  output  1  result valid
out_ready  input  1  consumer accepts result
num  output  16  binary result
err  output  1  at least one nibble > 9 in this transaction
ovf  output  1  true decimal value exceeds the range limit

Behaviour:
- Reset: asynchronous, active-high; takes effect immediately, independent of clk.
- Reset values: state=IDLE, in_ready=1, out_valid=0, num=0, err=0, ovf=0, accumulator=0.
- Reset mid-conversion aborts the transaction; no partial result is ever presented.
- States: IDLE, CONV, DONE.
- IDLE:
  - in_ready=1.
  - On an edge with in_valid=1: capture digits, clear acc/err/ovf, set idx=NDIG-1, go to CONV.
- CONV:
  - in_ready=0.
  - Each edge: acc = acc*10 + digits[idx]; idx decrements.
  - A nibble > 9 sets err (sticky for the transaction); its raw value is still used in acc.
  - After the edge that processes idx=0, go to DONE.
- DONE:
  - out_valid=1; num, err and ovf are stable.
  - Stay in DONE while out_ready=0.
  - On an edge with out_valid=1 and out_ready=1: go to IDLE, out_valid=0 next cycle.
- Latency: out_valid rises exactly NDIG cycles after the accepting edge. Throughput: one bundle per NDIG+2 cycles at best.
- in_ready is low in CONV and DONE. in_valid is ignored there; bundles offered then are neither captured nor queued.
- Width rules:
  - acc is 17 bits wide, enough for 99999 and any nibble pattern up to NDIG=5 with saturation.
  - Whenever acc*10 + digit exceeds 65535, set ovf and hold acc at 65535.
  - num = acc[15:0], except num = 0 when err=1.
- NDIG <= 4: ovf can never set without HACK_RANGE_EN.
- Changing digits after acceptance has no effect on the transaction in progress.
- out_ready asserted outside DONE has no effect.

Optional Feature:
Macro HACK_RANGE_EN.
- Defined: the range limit is 32767, the largest positive Hack A-instruction constant. A final acc > 32767 sets ovf, and num = 32767 (saturated).
- Undefined: the limit is 65535; num is the unsaturated acc[15:0] within that range.
- err handling and timing are identical in both builds.

Test Plan:
- Reset then NDIG=4, digits=16'h1234, in_valid for 1 cycle -> out_valid exactly 4 cycles after accept; num=1234, err=0, ovf=0.
- digits=16'h9999, out_ready held 0 for 5 cycles then 1 -> num=9999 held stable through the stall; out_valid drops after the handshake edge; in_ready returns to 1.
- digits=16'h12A4 -> err=1, num=0, ovf=0; the next bundle 16'h0042 -> num=42, err=0 (err is not carried over).
- NDIG=5, digits=20'h65536 -> ovf=1, num=65535. With HACK_RANGE_EN, digits=20'h40000 -> ovf=1, num=32767; without it -> num=40000, ovf=0.
- Assert rst for 1 cycle during the 2nd CONV cycle of 16'h5678 -> all outputs at reset values immediately; a fresh 16'h0007 converts to num=7.
- Second in_valid pulse during CONV -> not captured; only the first bundle's result appears; in_ready=0 throughout CONV and DONE.
